result_drain: RTL and testbench
===============================

# result_drain

Back end of the matrix-multiply path. It snapshots the N×N signed result matrix produced by the systolic array when a `capture` pulse arrives. It then streams the elements out one per handshake over a valid/ready interface in row-major order, with row/column tags and a last flag. It sits between the multiplier's `resultMatrix` output and any narrow consumer (memory writer, activation unit, host FIFO).

## Interface

Parameters:
- `WIDTH`, default 6: operand width of the multiplier; element width is `2*WIDTH`.
- `N`, default 3: matrix dimension; `N >= 2`.
- `IW`, derived as `$clog2(N)`: index width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `resultMatrix`  in  [N][N] × `2*WIDTH` signed  result from the systolic array.
- `capture`  in  1  load request; sampled only when `busy`=0.
- `busy`  out  1  high while a matrix is held and being streamed.
- `outData`  out  `2*WIDTH` signed  current element.
- `outRow`  out  `IW`  row index of `outData`.
- `outCol`  out  `IW`  column index of `outData`.
- `outValid`  out  1  `outData`/`outRow`/`outCol`/`outLast` are valid.
- `outReady`  in  1  consumer accepts the element when `outValid`&&`outReady`.
- `outLast`  out  1  high with element (N-1,N-1).
- `done`  out  1  one-cycle pulse after the final element is accepted.

## Operation

- Two-state FSM: IDLE, STREAM.
- IDLE:
  - `busy`=0, `outValid`=0.
  - On `capture`=1, copy all N² elements of `resultMatrix` into an internal buffer, set row=0 and col=0, and go to STREAM.
- STREAM:
  - `busy`=1 and `outValid`=1.
  - `outData` = buffer[row][col]; `outRow`=row; `outCol`=col.
  - `outLast` = (row==N-1 && col==N-1).
- Handshake (`outValid`&&`outReady`), handled in STREAM:
  - Not the last column: col+1.
  - col==N-1 and row<N-1: col=0, row+1.
  - Last element: go to IDLE, clear row/col, and assert `done` for the next cycle only.
- `capture` while `busy`=1 is ignored, including the cycle of the final handshake. No queuing and no error flag.
- The buffer is the only data source while streaming. Changes on `resultMatrix` after capture have no effect.
- Data passes through unmodified: no rounding, saturation or sign change.
- Reset (async, any state):
  - State goes to IDLE; row and col to 0; buffer to 0.
  - `busy`, `outValid`, `outLast` and `done` go to 0; `outData`, `outRow` and `outCol` go to 0.
  - A stream interrupted by reset is discarded. The next capture restarts at (0,0).

## Timing

- `capture` accepted at edge t: `outValid`=1 with element (0,0) from t+1.
- With `outReady` held at 1, one element per cycle:
  - Elements appear at t+1 … t+N².
  - `done`=1 and `busy`=0 at t+N²+1.
  - The earliest next capture is accepted at that same edge, giving a period of N²+1 cycles per matrix.
- Backpressure: while `outValid`=1 and `outReady`=0, `outData`, `outRow`, `outCol` and `outLast` hold stable. `outValid` never drops before a handshake.
- `outValid` does not depend combinationally on `outReady`.
- All outputs are driven from registers, or from a mux of registered buffer and index state. There is no combinational path from any input to any output.
- Reset is asserted asynchronously and released synchronously by the environment. The block samples nothing on the first edge while `rst_n`=0.

## Test plan

Common setup: N=3, WIDTH=6, `resultMatrix[i][j] = 10*i + j - 5`.

- **Reset:** with `rst_n`=0 mid-cycle, all outputs read 0 immediately. After release with `capture`=0 for 5 cycles, `outValid`, `busy` and `done` stay 0.
- **Full stream:** `capture` at edge t with `outReady`=1 throughout.
  - `outData` is -5,-4,-3,5,6,7,15,16,17 at t+1…t+9.
  - (row,col) is (0,0)…(2,2); `outLast` only at t+9.
  - `done`=1 only at t+10, and `busy` falls at t+10.
- **Backpressure and isolation:** `outReady` pattern 1,0,0,1,0,1,1,…
  - Each element is held until accepted and the order is unchanged.
  - After capture, `resultMatrix` is changed to all 0x7FF, and the stream still carries the original values.
- **Capture gating:**
  - `capture` pulses at t+3 and at the final-handshake cycle are ignored; exactly 9 elements and one `done` result.
  - `capture` at the `done` cycle starts a new stream at the next cycle.
- **Reset mid-stream:**
  - After 4 accepted elements, pulse `rst_n` low. `outValid`, `busy` and `outData` go to 0 immediately and no `done` is issued.
  - The next capture streams from (0,0), value -5.
- **Extremes:** `resultMatrix[0][0]`=-2048 and `resultMatrix[2][2]`=2047 are output bit-exact, with sign preserved on the 12-bit `outData`.

Source files
------------

// File: rtl/result_drain_if.sv
// Output stream of result_drain: one matrix element per valid/ready handshake,
// tagged with its row/column index and a last-element flag.
interface result_drain_if #(
  parameter int WIDTH = 6,
  parameter int N     = 3
) ();
  localparam int IW = $clog2(N);

  logic signed [2*WIDTH-1:0] outData;
  logic        [IW-1:0]      outRow;
  logic        [IW-1:0]      outCol;
  logic                      outValid;
  logic                      outReady;
  logic                      outLast;

  // Drain side produces the element stream and watches the consumer's ready.
  modport master (
    output outData, outRow, outCol, outValid, outLast,
    input  outReady
  );

  // Consumer side accepts elements.
  modport slave (
    input  outData, outRow, outCol, outValid, outLast,
    output outReady
  );
endinterface

// File: rtl/result_drain.sv
// Snapshots the N x N signed result matrix on a capture pulse, then streams the
// elements out in row-major order over a valid/ready interface, with row/column
// tags, a last flag and a one-cycle done pulse after the final element is taken.
module result_drain #(
  parameter  int WIDTH = 6,
  parameter  int N     = 3,
  localparam int IW    = $clog2(N),
  localparam int EW    = 2 * WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [EW-1:0] resultMatrix [N][N],
  input  logic                 capture,
  output logic                 busy,
  output logic                 done,
  result_drain_if.master       out_if
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         row_q, row_d;
  logic [IW-1:0]         col_q, col_d;
  logic signed [EW-1:0]  buf_q [N][N];
  logic signed [EW-1:0]  buf_d [N][N];
  logic                  done_q, done_d;

  logic streaming;
  logic at_last;

  assign streaming = (state_q == S_STREAM);
  assign at_last   = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  // Next-state: snapshot on capture in IDLE, walk row-major on each handshake.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (capture) begin
          buf_d   = resultMatrix;
          row_d   = '0;
          col_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        // capture is deliberately not looked at here: it is ignored while busy.
        if (out_if.outReady) begin
          if (col_q != LAST_IDX) begin
            col_d = col_q + 1'b1;
          end else if (row_q != LAST_IDX) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            row_d   = '0;
            col_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, index, buffer and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the snapshot buffer is reset as well, so outData reads 0 after
      // reset and a stream interrupted by reset leaves no stale data behind.
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      buf_q   <= '{default: '0};
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of the others.
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

  // Outputs come only from registered state and the registered buffer mux;
  // nothing here looks at outReady or capture.
  assign busy            = streaming;
  assign done            = done_q;
  assign out_if.outValid = streaming;
  assign out_if.outRow   = row_q;
  assign out_if.outCol   = col_q;
  assign out_if.outLast  = streaming && at_last;
  assign out_if.outData  = streaming ? buf_q[row_q][col_q] : '0;

endmodule

// File: tb/tb_result_drain.sv
// Directed testbench for result_drain (N=3, WIDTH=6). Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_result_drain;
  localparam int WIDTH = 6;
  localparam int N     = 3;
  localparam int EW    = 2 * WIDTH;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic capture = 1'b0;
  logic busy;
  logic done;
  logic signed [EW-1:0] mat     [N][N];
  logic signed [EW-1:0] exp_mat [N][N];

  int checks   = 0;
  int failures = 0;

  result_drain_if #(.WIDTH(WIDTH), .N(N)) bus ();

  result_drain #(.WIDTH(WIDTH), .N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .resultMatrix (mat),
    .capture      (capture),
    .busy         (busy),
    .done         (done),
    .out_if       (bus)
  );

  always #5 clk = ~clk;

  // resultMatrix[i][j] = 10*i + j - 5, mirrored into the expected matrix.
  task automatic load_standard();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat[i][j]     = 12'(10 * i + j - 5);
        exp_mat[i][j] = 12'(10 * i + j - 5);
      end
  endtask

  task automatic test_reset();
    bus.outReady = 1'b0;
    capture      = 1'b0;
    load_standard();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bus.outValid, bus.outLast, bus.outData, bus.outRow, bus.outCol} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b valid=%b last=%b data=%0d row=%0d col=%0d expected all 0",
               busy, done, bus.outValid, bus.outLast, bus.outData, bus.outRow, bus.outCol);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.outValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d valid=%b busy=%b done=%b expected 0 0 0",
                 c, bus.outValid, busy, done);
      end
    end
  endtask

  task automatic test_full_stream();
    int vals [9] = '{-5, -4, -3, 5, 6, 7, 15, 16, 17};
    load_standard();
    @(negedge clk) begin bus.outReady = 1'b1; capture = 1'b1; end
    @(negedge clk) capture = 1'b0;
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (bus.outValid !== 1'b1 || bus.outData !== 12'(vals[k]) ||
          bus.outRow !== 2'(k / 3) || bus.outCol !== 2'(k % 3) ||
          bus.outLast !== (k == 8) || done !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL full_stream elem %0d: valid=%b data=%0d row=%0d col=%0d last=%b done=%b busy=%b expected 1 %0d %0d %0d %b 0 1",
                 k, bus.outValid, bus.outData, bus.outRow, bus.outCol, bus.outLast, done, busy,
                 vals[k], k / 3, k % 3, (k == 8));
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.outValid !== 1'b0) begin
      failures++;
      $display("FAIL full_stream_done done=%b busy=%b valid=%b expected 1 0 0", done, busy, bus.outValid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL full_stream_done_pulse done=%b expected 0", done);
    end
  endtask

  task automatic test_backpressure();
    bit rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int idx = 0;
    int cyc = 0;
    load_standard();
    bus.outReady = 1'b0;
    @(negedge clk) capture = 1'b1;
    @(negedge clk) begin
      capture = 1'b0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          mat[i][j] = 12'h7FF;
    end
    while (idx < 9 && cyc < 40) begin
      checks++;
      if (bus.outValid !== 1'b1 || bus.outData !== exp_mat[idx / 3][idx % 3] ||
          bus.outRow !== 2'(idx / 3) || bus.outCol !== 2'(idx % 3) || bus.outLast !== (idx == 8)) begin
        failures++;
        $display("FAIL backpressure cycle %0d: valid=%b data=%0d row=%0d col=%0d last=%b expected 1 %0d %0d %0d %b",
                 cyc, bus.outValid, bus.outData, bus.outRow, bus.outCol, bus.outLast,
                 exp_mat[idx / 3][idx % 3], idx / 3, idx % 3, (idx == 8));
      end
      bus.outReady = (cyc < 7) ? rdy_pat[cyc] : 1'b1;
      if (bus.outReady && bus.outValid === 1'b1) idx++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (idx !== 9 || done !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_end accepted=%0d done=%b expected 9 1", idx, done);
    end
    load_standard();
  endtask

  task automatic test_capture_gating();
    int hs = 0;
    int dn = 0;
    load_standard();
    bus.outReady = 1'b1;
    @(negedge clk) capture = 1'b1;
    for (int o = 1; o <= 12; o++) begin
      @(negedge clk);
      if (bus.outValid === 1'b1) hs++;
      if (done === 1'b1) dn++;
      if (o == 11) begin
        checks++;
        if (bus.outValid !== 1'b0) begin
          failures++;
          $display("FAIL gating_no_restart valid=%b expected 0", bus.outValid);
        end
      end
      capture = (o == 3 || o == 9);
    end
    checks++;
    if (hs !== 9 || dn !== 1) begin
      failures++;
      $display("FAIL gating_counts elements=%0d dones=%0d expected 9 1", hs, dn);
    end
    // Capture on the done cycle starts the next stream immediately.
    @(negedge clk) capture = 1'b1;
    @(negedge clk) capture = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL gating_done_cycle done=%b busy=%b expected 1 0", done, busy);
    end
    capture = 1'b1;
    @(negedge clk) capture = 1'b0;
    checks++;
    if (bus.outValid !== 1'b1 || busy !== 1'b1 || bus.outData !== -12'sd5 ||
        bus.outRow !== 2'd0 || bus.outCol !== 2'd0) begin
      failures++;
      $display("FAIL capture_at_done valid=%b busy=%b data=%0d row=%0d col=%0d expected 1 1 -5 0 0",
               bus.outValid, busy, bus.outData, bus.outRow, bus.outCol);
    end
    repeat (9) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL capture_at_done_stream_end done=%b expected 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stream();
    load_standard();
    bus.outReady = 1'b1;
    @(negedge clk) capture = 1'b1;
    @(negedge clk) capture = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.outData !== 12'sd6 || bus.outRow !== 2'd1 || bus.outCol !== 2'd1) begin
      failures++;
      $display("FAIL mid_before_reset data=%0d row=%0d col=%0d expected 6 1 1",
               bus.outData, bus.outRow, bus.outCol);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.outValid !== 1'b0 || busy !== 1'b0 || bus.outData !== '0 || bus.outLast !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs valid=%b busy=%b data=%0d last=%b expected 0 0 0 0",
               bus.outValid, busy, bus.outData, bus.outLast);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (done !== 1'b0 || bus.outValid !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_no_done cycle %0d done=%b valid=%b expected 0 0", c, done, bus.outValid);
      end
      @(negedge clk);
    end
    capture = 1'b1;
    @(negedge clk) capture = 1'b0;
    checks++;
    if (bus.outValid !== 1'b1 || bus.outData !== -12'sd5 || bus.outRow !== 2'd0 || bus.outCol !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset_restart valid=%b data=%0d row=%0d col=%0d expected 1 -5 0 0",
               bus.outValid, bus.outData, bus.outRow, bus.outCol);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_extremes();
    load_standard();
    mat[0][0]     = 12'sh800;
    exp_mat[0][0] = 12'sh800;
    mat[2][2]     = 12'sh7FF;
    exp_mat[2][2] = 12'sh7FF;
    bus.outReady = 1'b1;
    @(negedge clk) capture = 1'b1;
    @(negedge clk) capture = 1'b0;
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (bus.outValid !== 1'b1 || bus.outData !== exp_mat[k / 3][k % 3]) begin
        failures++;
        $display("FAIL extremes elem %0d valid=%b data=%h expected 1 %h",
                 k, bus.outValid, bus.outData, exp_mat[k / 3][k % 3]);
      end
      if (k == 0) begin
        checks++;
        if (!(bus.outData < 0) || bus.outData !== -12'sd2048) begin
          failures++;
          $display("FAIL extremes_min data=%0d expected -2048", bus.outData);
        end
      end
      if (k == 8) begin
        checks++;
        if (bus.outData !== 12'sd2047 || bus.outLast !== 1'b1) begin
          failures++;
          $display("FAIL extremes_max data=%0d last=%b expected 2047 1", bus.outData, bus.outLast);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL extremes_done done=%b expected 1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_backpressure();
    test_capture_gating();
    test_reset_mid_stream();
    test_extremes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
